// File: rtl/vram_scanout.sv
// rtl/vram_scanout.sv - raster-order VRAM reader streaming density samples; optional clear-on-read via VRAM_CLEAR_ON_READ_EN
module vram_scanout #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int DENS_W = 8,
    parameter int RD_LAT = 2,
    parameter int FIFO_D = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_start,
    output logic              io_busy,
    output logic              io_frame_done,
    output logic [31:0]       io_ram_addra,
    output logic [31:0]       io_ram_dina,
    input  logic [31:0]       io_ram_douta,
    output logic              io_ram_ena,
    output logic              io_ram_wea,
    output logic              io_pix_valid,
    input  logic              io_pix_ready,
    output logic [DENS_W-1:0] io_pix_density,
    output logic [9:0]        io_pix_x,
    output logic [9:0]        io_pix_y,
    output logic              io_pix_sof,
    output logic              io_pix_eol
);

    localparam int          AW        = $clog2(FIFO_D);
    localparam int          CW        = AW + 1;
    localparam logic [31:0] LAST_ADDR = 32'(H_RES * V_RES - 1);
    localparam logic [9:0]  X_LAST    = 10'(H_RES - 1);
    localparam logic [9:0]  Y_LAST    = 10'(V_RES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Issue side: linear word address plus the raster position it corresponds to
    logic [31:0]   addr_q;
    logic [9:0]    ix_q, iy_q;

    // Reads travelling through the RAM pipeline, tagged with their raster position
    logic          pipe_v_q   [RD_LAT];
    logic [9:0]    pipe_x_q   [RD_LAT];
    logic [9:0]    pipe_y_q   [RD_LAT];
    logic          pipe_sof_q [RD_LAT];
    logic          pipe_eol_q [RD_LAT];
    logic [CW-1:0] in_flight_q;

    // Prefetch FIFO
    logic [DENS_W-1:0] fifo_dens [FIFO_D];
    logic [9:0]        fifo_x    [FIFO_D];
    logic [9:0]        fifo_y    [FIFO_D];
    logic              fifo_sof  [FIFO_D];
    logic              fifo_eol  [FIFO_D];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]     count_q;

    logic          clear_now;
    logic [CW:0]   credit_sum;
    logic          credit_ok;
    logic          rd_issue;
    logic          last_issue;
    logic          land;
    logic          pop;
    logic          head_last;
    logic          unused_douta;

`ifdef VRAM_CLEAR_ON_READ_EN
    logic          clear_pend_q;
    logic [31:0]   clear_addr_q;

    // The write-back of zero follows each read by exactly one cycle and owns the port that cycle
    always_ff @(posedge clock) begin
        if (reset) begin
            clear_pend_q <= 1'b0;
            clear_addr_q <= '0;
        end else begin
            clear_pend_q <= rd_issue;
            if (rd_issue) begin
                clear_addr_q <= addr_q;
            end
        end
    end

    assign clear_now = clear_pend_q;
`else
    assign clear_now = 1'b0;
`endif

    assign unused_douta = ^io_ram_douta[31:DENS_W];

    // A slot is reserved in the FIFO at issue time, so landing data always has room
    assign credit_sum = {1'b0, in_flight_q} + {1'b0, count_q};
    assign credit_ok  = credit_sum < (CW + 1)'(FIFO_D);
    assign rd_issue   = (state_q == ST_SCAN) && credit_ok && !clear_now;
    assign last_issue = rd_issue && (addr_q == LAST_ADDR);
    assign land       = pipe_v_q[RD_LAT-1];

    assign io_pix_valid  = (count_q != '0);
    assign pop           = io_pix_valid && io_pix_ready;
    assign head_last     = fifo_eol[rd_ptr_q] && (fifo_y[rd_ptr_q] == Y_LAST);
    assign io_frame_done = pop && head_last;
    assign io_busy       = (state_q != ST_IDLE);

    // Head fields are forced to zero when nothing is presented so idle outputs read 0
    assign io_pix_density = io_pix_valid ? fifo_dens[rd_ptr_q] : '0;
    assign io_pix_x       = io_pix_valid ? fifo_x[rd_ptr_q]    : '0;
    assign io_pix_y       = io_pix_valid ? fifo_y[rd_ptr_q]    : '0;
    assign io_pix_sof     = io_pix_valid ? fifo_sof[rd_ptr_q]  : 1'b0;
    assign io_pix_eol     = io_pix_valid ? fifo_eol[rd_ptr_q]  : 1'b0;

    assign io_ram_dina = '0;

    // RAM port drive: a pending clear write and a read never share a cycle
    always_comb begin
        io_ram_ena   = 1'b0;
        io_ram_wea   = 1'b0;
        io_ram_addra = '0;
        if (rd_issue) begin
            io_ram_ena   = 1'b1;
            io_ram_addra = addr_q;
        end
`ifdef VRAM_CLEAR_ON_READ_EN
        if (clear_pend_q) begin
            io_ram_ena   = 1'b1;
            io_ram_wea   = 1'b1;
            io_ram_addra = clear_addr_q;
        end
`endif
    end

    // Next-state: the final handshake ends the frame so busy drops the following cycle
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (io_start) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (last_issue) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (io_frame_done ||
                    (count_q == '0 && in_flight_q == '0 && !clear_now)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Address and raster counters advance together, avoiding a y*H_RES multiply
    always_ff @(posedge clock) begin
        if (reset) begin
            addr_q <= '0;
            ix_q   <= '0;
            iy_q   <= '0;
        end else if (state_q == ST_IDLE && io_start) begin
            addr_q <= '0;
            ix_q   <= '0;
            iy_q   <= '0;
        end else if (rd_issue) begin
            addr_q <= addr_q + 32'd1;
            if (ix_q == X_LAST) begin
                ix_q <= '0;
                iy_q <= iy_q + 10'd1;
            end else begin
                ix_q <= ix_q + 10'd1;
            end
        end
    end

    // Tag shift register aligned with the RAM read latency
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_v_q[k] <= 1'b0;
            end
        end else begin
            pipe_v_q[0] <= rd_issue;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_v_q[k] <= pipe_v_q[k-1];
            end
        end
        pipe_x_q[0]   <= ix_q;
        pipe_y_q[0]   <= iy_q;
        pipe_sof_q[0] <= (ix_q == '0) && (iy_q == '0);
        pipe_eol_q[0] <= (ix_q == X_LAST);
        for (int k = 1; k < RD_LAT; k++) begin
            pipe_x_q[k]   <= pipe_x_q[k-1];
            pipe_y_q[k]   <= pipe_y_q[k-1];
            pipe_sof_q[k] <= pipe_sof_q[k-1];
            pipe_eol_q[k] <= pipe_eol_q[k-1];
        end
    end

    // Count of reads issued but not yet landed in the FIFO
    always_ff @(posedge clock) begin
        if (reset) begin
            in_flight_q <= '0;
        end else begin
            case ({rd_issue, land})
                2'b10:   in_flight_q <= in_flight_q + 1'b1;
                2'b01:   in_flight_q <= in_flight_q - 1'b1;
                default: in_flight_q <= in_flight_q;
            endcase
        end
    end

    // FIFO pointers and occupancy; simultaneous push and pop leaves count unchanged
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (land) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({land, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage captures the RAM word in the cycle its tag reaches the end of the pipe
    always_ff @(posedge clock) begin
        if (land) begin
            fifo_dens[wr_ptr_q] <= io_ram_douta[DENS_W-1:0];
            fifo_x[wr_ptr_q]    <= pipe_x_q[RD_LAT-1];
            fifo_y[wr_ptr_q]    <= pipe_y_q[RD_LAT-1];
            fifo_sof[wr_ptr_q]  <= pipe_sof_q[RD_LAT-1];
            fifo_eol[wr_ptr_q]  <= pipe_eol_q[RD_LAT-1];
        end
    end

endmodule

// File: tb/tb_vram_scanout.sv
// tb/tb_vram_scanout.sv - directed bench for vram_scanout on an 8x4 frame
module tb_vram_scanout;

    localparam int H    = 8;
    localparam int V    = 4;
    localparam int NPIX = H * V;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        ready = 1'b0;
    logic        busy, frame_done, ena, wea, valid, sof, eol;
    logic [31:0] addra, dina, douta;
    logic [7:0]  dens;
    logic [9:0]  px, py;

    always #5 clk = ~clk;

    vram_scanout #(.H_RES(H), .V_RES(V), .DENS_W(8), .RD_LAT(2), .FIFO_D(4)) dut (
        .clock(clk), .reset(rst), .io_start(start), .io_busy(busy),
        .io_frame_done(frame_done), .io_ram_addra(addra), .io_ram_dina(dina),
        .io_ram_douta(douta), .io_ram_ena(ena), .io_ram_wea(wea),
        .io_pix_valid(valid), .io_pix_ready(ready), .io_pix_density(dens),
        .io_pix_x(px), .io_pix_y(py), .io_pix_sof(sof), .io_pix_eol(eol)
    );

    // RAM model with two-cycle read latency
    logic [31:0] mem [NPIX];
    logic [31:0] rd_p1, rd_p2;
    logic        preload = 1'b1;
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < NPIX; i++) mem[i] <= 32'(i & 8'hFF);
        end else if (ena && wea) begin
            mem[addra[4:0]] <= dina;
        end
        if (ena && !wea) rd_p1 <= mem[addra[4:0]];
        rd_p2 <= rd_p1;
    end
    assign douta = rd_p2;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Monitor: captures handshakes and protocol violations at the falling edge
    logic        mon_clr = 1'b1;
    int          cyc = 0, n, issued, credit_viol, stall_viol, wr_viol, wr_cnt;
    int          fd_cnt, fd_cyc, busy_fall_cyc, first_hs, last_hs;
    logic [30:0] cap [64];
    logic        prev_stall, prev_busy, prev_rd;
    logic [30:0] prev_word;
    logic [31:0] prev_addr;
    logic [30:0] cur_word;

    always @(negedge clk) begin
        cyc++;
        cur_word = {frame_done, eol, sof, py, px, dens};
        if (mon_clr) begin
            n = 0; issued = 0; credit_viol = 0; stall_viol = 0; wr_viol = 0; wr_cnt = 0;
            fd_cnt = 0; fd_cyc = -100; busy_fall_cyc = -200; first_hs = -1; last_hs = -1;
            prev_stall = 1'b0; prev_busy = 1'b0; prev_rd = 1'b0; prev_addr = '0;
        end else if (!rst) begin
            if (ena && !wea) begin
                if (issued - n >= 4) credit_viol++;
                issued++;
            end
            if (ena && wea) begin
                wr_cnt++;
                if (!(prev_rd && prev_addr == addra)) wr_viol++;
            end
            if (prev_stall && (!valid || cur_word[29:0] != prev_word[29:0])) stall_viol++;
            if (valid && ready) begin
                if (n < 64) cap[n] = cur_word;
                if (first_hs < 0) first_hs = cyc;
                last_hs = cyc;
                n++;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_cyc = cyc;
            end
            if (prev_busy && !busy) busy_fall_cyc = cyc;
            prev_stall = valid && !ready;
            prev_word  = cur_word;
            prev_busy  = busy;
            prev_rd    = ena && !wea;
            prev_addr  = addra;
        end
    end

    function automatic logic [30:0] exp_word(input int i, input bit zero);
        logic [9:0] x = 10'(i % H);
        logic [9:0] y = 10'(i / H);
        logic [7:0] d = zero ? 8'd0 : 8'(i);
        return {(i == NPIX - 1), (i % H == H - 1), (i == 0), y, x, d};
    endfunction

    task automatic clear_mon();
        @(posedge clk); #1 mon_clr = 1'b1;
        @(posedge clk); #1 mon_clr = 1'b0;
    endtask

    // mode 0: ready high, 1: alternate, 2: random, 3: held low 20 cycles, 4: extra starts
    task automatic run_frame(input int mode);
        bit done = 1'b0;
        clear_mon();
        for (int c = 0; c < 3000 && !done; c++) begin
            @(posedge clk); #1;
            start = (c == 0) || (mode == 4 && c == 12);
            case (mode)
                1:       ready = (c % 2 == 0);
                2:       ready = 1'($urandom_range(0, 1));
                3:       ready = (c > 20);
                default: ready = 1'b1;
            endcase
            #1;
            if (mode == 3 && c == 20) begin
                check_eq("hold_issued", 32'(issued), 32'd4);
                check_eq("hold_ena", {31'd0, ena}, 32'd0);
                check_eq("hold_none_out", 32'(n), 32'd0);
            end
            if (mode == 4 && frame_done) start = 1'b1;
            if (c > 2 && n >= NPIX && !busy) done = 1'b1;
        end
        @(posedge clk); #1 start = 1'b0;
        if (!done) check_eq("frame_timeout", 32'd1, 32'd0);
    endtask

    task automatic verify_frame(input string tag, input bit zero);
        int bad = 0;
        check_eq({tag, "_count"}, 32'(n), 32'(NPIX));
        for (int i = 0; i < NPIX; i++) begin
            if (cap[i] !== exp_word(i, zero)) begin
                bad++;
                check_eq($sformatf("%s_s%0d", tag, i), {1'b0, cap[i]}, {1'b0, exp_word(i, zero)});
            end
        end
        check_eq({tag, "_samples_bad"}, 32'(bad), 32'd0);
        check_eq({tag, "_fd_cnt"}, 32'(fd_cnt), 32'd1);
        check_eq({tag, "_busy_after_fd"}, 32'(busy_fall_cyc - fd_cyc), 32'd1);
        check_eq({tag, "_credit"}, 32'(credit_viol), 32'd0);
        check_eq({tag, "_stall_stable"}, 32'(stall_viol), 32'd0);
    endtask

    initial begin
        logic [31:0] mem_or;
        bit          hit;
        repeat (3) @(posedge clk);
        #1 preload = 1'b0;
        #1;
        check_eq("rst_valid", {31'd0, valid}, 32'd0);
        check_eq("rst_busy", {31'd0, busy}, 32'd0);
        check_eq("rst_ena", {31'd0, ena}, 32'd0);
        check_eq("rst_fd", {31'd0, frame_done}, 32'd0);
        check_eq("rst_addra", addra, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

`ifndef VRAM_CLEAR_ON_READ_EN
        run_frame(0);
        verify_frame("ready1", 1'b0);
        check_eq("ready1_rate", 32'(last_hs - first_hs), 32'(NPIX - 1));
        check_eq("ready1_wea", 32'(wr_cnt), 32'd0);

        run_frame(1);
        verify_frame("toggle", 1'b0);
        run_frame(2);
        verify_frame("random", 1'b0);
        run_frame(3);
        verify_frame("hold", 1'b0);

        run_frame(4);
        verify_frame("restart", 1'b0);
        repeat (20) @(posedge clk);
        #2;
        check_eq("restart_idle_busy", {31'd0, busy}, 32'd0);
        check_eq("restart_idle_n", 32'(n), 32'(NPIX));

        // Reset at the 10th handshake
        clear_mon();
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            @(posedge clk); #1;
            start = (c == 0);
            ready = 1'b1;
            #1;
            if (valid && ready && n == 9) begin
                rst = 1'b1;
                hit = 1'b1;
            end
        end
        check_eq("mid_rst_reached", {31'd0, hit}, 32'd1);
        @(posedge clk); #1 rst = 1'b0; start = 1'b0;
        #1;
        check_eq("mid_rst_valid", {31'd0, valid}, 32'd0);
        check_eq("mid_rst_busy", {31'd0, busy}, 32'd0);
        check_eq("mid_rst_ena", {31'd0, ena}, 32'd0);
        run_frame(0);
        verify_frame("after_rst", 1'b0);
`else
        run_frame(0);
        verify_frame("clr1", 1'b0);
        check_eq("clr1_rate", 32'(last_hs - first_hs), 32'(2 * (NPIX - 1)));
        check_eq("clr1_writes", 32'(wr_cnt), 32'(NPIX));
        check_eq("clr1_write_follow", 32'(wr_viol), 32'd0);
        mem_or = '0;
        for (int i = 0; i < NPIX; i++) mem_or = mem_or | mem[i];
        check_eq("clr1_ram_zero", mem_or, 32'd0);
        run_frame(3);
        verify_frame("clr2", 1'b1);
        check_eq("clr2_write_follow", 32'(wr_viol), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
